// File: rtl/count_mon_pkg.sv
// Shared types for the counter event monitor: event codes, FSM states and
// the timestamped event record carried through the FIFO.
package count_mon_pkg;

    localparam int unsigned CM_WIDTH   = 8;
    localparam int unsigned CM_STAMP_W = 16;

    typedef enum logic [1:0] {
        EVT_WRAP     = 2'b01,
        EVT_THRESH   = 2'b10,
        EVT_STEP_ERR = 2'b11
    } evt_code_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } mon_state_t;

    typedef struct packed {
        evt_code_t               code;
        logic [CM_WIDTH-1:0]     count;
        logic [CM_STAMP_W-1:0]   stamp;
    } evt_rec_t;

endpackage

// File: rtl/evt_fifo.sv
// First-word-fall-through FIFO of event records; the head output holds the
// last shown record while empty.
module evt_fifo
    import count_mon_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     flush,
    input  logic     push,
    input  evt_rec_t din,
    output logic     full,
    input  logic     pop,
    output logic     empty,
    output evt_rec_t head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    evt_rec_t    mem_q [DEPTH];
    evt_rec_t    last_q;
    logic        do_push;
    logic        do_pop;

    // Pointer update; a push into a full FIFO only lands if a pop frees the slot.
    always_comb begin
        empty   = (wr_q == rd_q);
        full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        do_pop  = pop && !empty && !flush;
        do_push = push && !flush && (!full || do_pop);
        head    = empty ? last_q : mem_q[rd_q[AW-1:0]];
        wr_d    = wr_q;
        rd_d    = rd_q;
        if (flush) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + (AW+1)'(1);
            if (do_pop)  rd_d = rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q   <= '0;
            rd_q   <= '0;
            last_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            last_q <= head;
            if (do_push) mem_q[wr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/count_event_monitor.sv
// Watches a free-running counter for legal +1 steps and queues timestamped
// WRAP / THRESH / STEP_ERR records for a valid/ready consumer.
module count_event_monitor
    import count_mon_pkg::*;
#(
    parameter logic [CM_WIDTH-1:0] THRESH     = CM_WIDTH'(8'hC0),
    parameter int unsigned         FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CM_WIDTH-1:0]   count_in,
    input  logic                  enable,
    input  logic                  clear,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [1:0]            evt_code,
    output logic [CM_WIDTH-1:0]   evt_count,
    output logic [CM_STAMP_W-1:0] evt_stamp,
    output logic                  overflow
);

    mon_state_t            state_q, state_d;
    logic [CM_WIDTH-1:0]   prev_q, prev_d;
    logic [CM_STAMP_W-1:0] stamp_q, stamp_d;
    logic                  pend_valid_q, pend_valid_d;
    evt_rec_t              pend_rec_q, pend_rec_d;
    logic                  overflow_q, overflow_d;

    logic                  step_ok;
    logic                  hit;
    evt_code_t             code_sel;
    logic                  fifo_full;
    logic                  fifo_empty;
    evt_rec_t              fifo_head;

    // Sequencing and classification; a detected event waits one cycle in the pending stage.
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        stamp_d      = stamp_q + CM_STAMP_W'(1);
        pend_valid_d = 1'b0;
        pend_rec_d   = pend_rec_q;
        hit          = 1'b0;
        code_sel     = EVT_STEP_ERR;
        step_ok      = (count_in == CM_WIDTH'(prev_q + CM_WIDTH'(1)));

        if (clear) begin
            state_d = enable ? PRIME : IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) state_d = PRIME;
                end
                PRIME: begin
                    if (!enable) begin
                        state_d = IDLE;
                    end else begin
                        prev_d  = count_in;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state_d = IDLE;
                    end else begin
                        prev_d = count_in;
                        if (!step_ok) begin
                            hit      = 1'b1;
                            code_sel = EVT_STEP_ERR;
                        end else if (count_in == '0) begin
                            hit      = 1'b1;
                            code_sel = EVT_WRAP;
                        end else if (count_in == THRESH) begin
                            hit      = 1'b1;
                            code_sel = EVT_THRESH;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (hit) begin
            pend_valid_d = 1'b1;
            pend_rec_d   = '{code: code_sel, count: count_in, stamp: stamp_q};
        end
    end

    // Sticky drop flag: the FIFO is full and the head is not leaving this cycle.
    always_comb begin
        overflow_d = overflow_q;
        if (clear) begin
            overflow_d = 1'b0;
        end else if (pend_valid_q && fifo_full && !evt_ready) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            prev_q       <= '0;
            stamp_q      <= '0;
            pend_valid_q <= 1'b0;
            pend_rec_q   <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            stamp_q      <= stamp_d;
            pend_valid_q <= pend_valid_d;
            pend_rec_q   <= pend_rec_d;
            overflow_q   <= overflow_d;
        end
    end

    evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (clear),
        .push  (pend_valid_q && !clear),
        .din   (pend_rec_q),
        .full  (fifo_full),
        .pop   (evt_ready),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign evt_valid = !fifo_empty;
    assign evt_code  = fifo_head.code;
    assign evt_count = fifo_head.count;
    assign evt_stamp = fifo_head.stamp;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_count_event_monitor.sv
// Scoreboard bench: stimulus queues hand-computed records, a negedge monitor
// pops and compares each record the DUT hands over.
module tb_count_event_monitor;
    import count_mon_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  count_in;
    logic        enable;
    logic        clear;
    logic        evt_valid;
    logic        evt_ready;
    logic [1:0]  evt_code;
    logic [7:0]  evt_count;
    logic [15:0] evt_stamp;
    logic        overflow;

    int          checks   = 0;
    int          failures = 0;
    int          popped   = 0;
    logic [15:0] tbst;
    logic [15:0] s13;
    evt_rec_t    expq[$];
    evt_rec_t    mon_e;

    always #5 clk = ~clk;

    count_event_monitor #(
        .THRESH     (8'hC0),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .count_in  (count_in),
        .enable    (enable),
        .clear     (clear),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_code  (evt_code),
        .evt_count (evt_count),
        .evt_stamp (evt_stamp),
        .overflow  (overflow)
    );

    // Reference cycle stamp: counts clock edges since reset release.
    always @(posedge clk or negedge reset) begin
        if (!reset) tbst <= '0;
        else        tbst <= tbst + 16'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] c, input bit evt, input evt_code_t code);
        count_in = c;
        if (evt) expq.push_back('{code: code, count: c, stamp: tbst});
        cyc();
    endtask

    // Monitor: every accepted record must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset && evt_valid && evt_ready) begin
            popped++;
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_record actual code=%0d count=%0h stamp=%0h required=none",
                         evt_code, evt_count, evt_stamp);
            end else begin
                mon_e = expq.pop_front();
                check("rec_code",  32'(evt_code),  32'(mon_e.code));
                check("rec_count", 32'(evt_count), 32'(mon_e.count));
                check("rec_stamp", 32'(evt_stamp), 32'(mon_e.stamp));
            end
        end
    end

    initial begin
        reset     = 1'b0;
        enable    = 1'b0;
        clear     = 1'b0;
        evt_ready = 1'b1;
        count_in  = 8'h00;
        #12;
        check("rst_valid",    32'(evt_valid), 32'd0);
        check("rst_overflow", 32'(overflow),  32'd0);
        check("rst_code",     32'(evt_code),  32'd0);
        check("rst_count",    32'(evt_count), 32'd0);
        check("rst_stamp",    32'(evt_stamp), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        cyc();
        cyc();

        // Legal count sequence 0x00..0xFF..0x05: one THRESH, one WRAP
        enable = 1'b1;
        for (int i = 0; i < 262; i++) begin
            if (i == 192)      drive(8'(i), 1'b1, EVT_THRESH);
            else if (i == 256) drive(8'(i), 1'b1, EVT_WRAP);
            else               drive(8'(i), 1'b0, EVT_WRAP);
        end
        enable = 1'b0;
        repeat (4) cyc();
        check("t1_records",  32'(popped),    32'd2);
        check("t1_overflow", 32'(overflow),  32'd0);
        check("t1_valid",    32'(evt_valid), 32'd0);

        // Jump 0x10 -> 0x13, then held 0x13
        enable = 1'b1;
        drive(8'h10, 1'b0, EVT_WRAP);
        drive(8'h10, 1'b0, EVT_WRAP);
        s13 = tbst;
        drive(8'h13, 1'b1, EVT_STEP_ERR);
        check("t2_valid_early", 32'(evt_valid), 32'd0);
        drive(8'h13, 1'b1, EVT_STEP_ERR);
        check("t2_valid", 32'(evt_valid), 32'd1);
        check("t2_code",  32'(evt_code),  32'd3);
        check("t2_count", 32'(evt_count), 32'h13);
        check("t2_stamp", 32'(evt_stamp), 32'(s13));
        drive(8'h14, 1'b0, EVT_WRAP);
        enable = 1'b0;
        repeat (4) cyc();
        check("t2_records", 32'(popped), 32'd4);

        // Five STEP_ERR with consumer stalled: fifth is dropped
        evt_ready = 1'b0;
        enable    = 1'b1;
        drive(8'h30, 1'b0, EVT_WRAP);
        drive(8'h30, 1'b0, EVT_WRAP);
        drive(8'h21, 1'b1, EVT_STEP_ERR);
        drive(8'h23, 1'b1, EVT_STEP_ERR);
        drive(8'h25, 1'b1, EVT_STEP_ERR);
        drive(8'h27, 1'b1, EVT_STEP_ERR);
        drive(8'h29, 1'b0, EVT_STEP_ERR);
        check("t3_ovf_before", 32'(overflow),  32'd0);
        check("t3_valid",      32'(evt_valid), 32'd1);
        enable = 1'b0;
        cyc();
        check("t3_ovf_after", 32'(overflow), 32'd1);
        evt_ready = 1'b1;
        repeat (6) cyc();
        check("t3_records",  32'(popped),    32'd8);
        check("t3_empty",    32'(evt_valid), 32'd0);
        check("t3_ovf_keep", 32'(overflow),  32'd1);

        // Clear with three queued records and overflow set
        evt_ready = 1'b0;
        enable    = 1'b1;
        drive(8'h40, 1'b0, EVT_WRAP);
        drive(8'h40, 1'b0, EVT_WRAP);
        drive(8'h50, 1'b0, EVT_WRAP);
        drive(8'h60, 1'b0, EVT_WRAP);
        drive(8'h70, 1'b0, EVT_WRAP);
        drive(8'h71, 1'b0, EVT_WRAP);
        check("t4_pre_valid", 32'(evt_valid), 32'd1);
        check("t4_pre_ovf",   32'(overflow),  32'd1);
        clear    = 1'b1;
        count_in = 8'h90;
        cyc();
        clear = 1'b0;
        check("t4_clr_valid", 32'(evt_valid), 32'd0);
        check("t4_clr_ovf",   32'(overflow),  32'd0);
        drive(8'hA5, 1'b0, EVT_WRAP);
        drive(8'hA6, 1'b0, EVT_WRAP);
        enable    = 1'b0;
        evt_ready = 1'b1;
        repeat (3) cyc();
        check("t4_reprime_valid", 32'(evt_valid), 32'd0);
        check("t4_records",       32'(popped),    32'd8);

        // Full FIFO: pop and push in the same cycle
        evt_ready = 1'b0;
        enable    = 1'b1;
        drive(8'h00, 1'b0, EVT_WRAP);
        drive(8'h80, 1'b0, EVT_WRAP);
        drive(8'h82, 1'b1, EVT_STEP_ERR);
        drive(8'h84, 1'b1, EVT_STEP_ERR);
        drive(8'h86, 1'b1, EVT_STEP_ERR);
        drive(8'h88, 1'b1, EVT_STEP_ERR);
        drive(8'h8A, 1'b1, EVT_STEP_ERR);
        check("t5_full_valid", 32'(evt_valid), 32'd1);
        evt_ready = 1'b1;
        drive(8'h8B, 1'b0, EVT_WRAP);
        evt_ready = 1'b0;
        check("t5_ovf",    32'(overflow), 32'd0);
        check("t5_popped", 32'(popped),   32'd9);
        enable = 1'b0;
        cyc();
        evt_ready = 1'b1;
        repeat (4) cyc();
        check("t5_records", 32'(popped),    32'd13);
        check("t5_empty",   32'(evt_valid), 32'd0);

        // Reset mid-drain, then re-prime on 0x57
        evt_ready = 1'b0;
        enable    = 1'b1;
        drive(8'h00, 1'b0, EVT_WRAP);
        drive(8'h10, 1'b0, EVT_WRAP);
        drive(8'h30, 1'b1, EVT_STEP_ERR);
        drive(8'h40, 1'b1, EVT_STEP_ERR);
        drive(8'h41, 1'b0, EVT_WRAP);
        enable    = 1'b0;
        evt_ready = 1'b1;
        cyc();
        check("t6_pre_valid", 32'(evt_valid), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("t6_rst_valid", 32'(evt_valid), 32'd0);
        check("t6_rst_count", 32'(evt_count), 32'd0);
        check("t6_rst_stamp", 32'(evt_stamp), 32'd0);
        #3 reset = 1'b1;
        expq.delete();
        enable = 1'b1;
        drive(8'h57, 1'b0, EVT_WRAP);
        drive(8'h57, 1'b0, EVT_WRAP);
        drive(8'h58, 1'b0, EVT_WRAP);
        drive(8'h59, 1'b0, EVT_WRAP);
        check("t6_no_event", 32'(evt_valid), 32'd0);
        drive(8'h70, 1'b1, EVT_STEP_ERR);
        enable = 1'b0;
        repeat (3) cyc();
        check("t6_records", 32'(popped),      32'd15);
        check("exp_left",   32'(expq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/count_event_monitor.md
Name: count_event_monitor

Overview:
- Downstream consumer of the 8-bit free-running counter's `count` output.
- Checks every sample for a legal +1 step and flags three event types: wrap-around, threshold crossing and step errors.
- Each event is queued as a timestamped record in a small FIFO and drained over a valid/ready interface.
- Serves as a hardware self-check of the counter and an event source for later logic.

Parameters:
- WIDTH, 8, width of count_in and evt_count.
- THRESH, 8'hC0, count value that raises a THRESH event when reached by a legal step.
- FIFO_DEPTH, 4, event FIFO entries; power of two, minimum 2.
- STAMP_W, 16, timestamp width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- count_in  in  WIDTH  counter value under observation.
- enable  in  1  1 = monitor samples count_in every cycle.
- clear  in  1  synchronous flush: empties FIFO, clears overflow, re-primes.
- evt_valid  out  1  head FIFO record is valid.
- evt_ready  in  1  consumer accepts record; pop when evt_valid && evt_ready.
- evt_code  out  2  01 WRAP, 10 THRESH, 11 STEP_ERR (00 unused).
- evt_count  out  WIDTH  count_in value that produced the event.
- evt_stamp  out  STAMP_W  cycle stamp at detection.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.

Behaviour:
- Reset (reset=0, async): all outputs 0, FIFO empty, stamp counter 0, prev 0, FSM=IDLE.
- Stamp counter:
  - Increments every clk after reset release, regardless of enable.
  - Wraps modulo 2^STAMP_W.
- FSM states and transitions:
  - IDLE: no checking. enable=1 -> PRIME.
  - PRIME: capture prev<=count_in, emit no event -> RUN; enable=0 -> IDLE.
  - RUN:
    - Each edge, compare count_in against prev, then prev<=count_in.
    - enable=0 -> IDLE.
    - clear=1 -> PRIME, with clear taking priority over enable.
- Event classification in RUN; at most one event per cycle, in this priority:
  - STEP_ERR if count_in != (prev+1) mod 2^WIDTH. This includes a held value.
  - Else WRAP if count_in==0.
  - Else THRESH if count_in==THRESH.
  - If THRESH==0, WRAP wins.
- Latency: the sample registered at edge N is classified and pushed at edge N+1, so evt_valid is high after edge N+1 when the FIFO was empty.
- FIFO behaviour:
  - First-word-fall-through: evt_code, evt_count and evt_stamp show the head record whenever evt_valid=1.
  - When empty, evt_valid=0 and the data outputs hold their last value.
  - Push when full with no pop in the same cycle: record dropped, overflow<=1, FIFO contents untouched.
  - Push and pop in the same cycle when full: both occur, overflow unchanged.
  - Push and pop in the same cycle when empty: the push occurs and no pop, since evt_valid was 0.
  - Record order strictly preserved.
- clear:
  - Takes effect at the next edge: FIFO empty, overflow=0, FSM=PRIME if enable else IDLE.
  - An event detected in the same cycle as clear is discarded.
  - The stamp counter is not cleared.
- enable deasserted: the FIFO keeps draining normally and no new events are generated.
- Reset asserted mid-operation: outputs go to 0 immediately (async), pending records are lost, and the first sample after release is never checked.

Decomposition:
- Package count_mon_pkg:
  - evt_code_t enum (EVT_WRAP=2'b01, EVT_THRESH=2'b10, EVT_STEP_ERR=2'b11).
  - mon_state_t enum (IDLE, PRIME, RUN).
  - evt_rec_t packed struct {code, count, stamp}.
- Sub-module evt_fifo:
  - Synchronous FWFT FIFO of evt_rec_t, parameterized by depth.
  - Ports: push, full, pop, empty, head.
  - Pointers are one bit wider than the address for full/empty detection.

Test Plan:
- Counter runs 0x00..0xFF..0x05 with enable=1, evt_ready=1 -> exactly two records: {THRESH, 0xC0} then {WRAP, 0x00}; no STEP_ERR; overflow=0.
- count_in forced 0x10 -> 0x13 -> record {STEP_ERR, 0x13}, with evt_stamp equal to the stamp at the 0x13 sample; a held value 0x13 -> 0x13 also yields STEP_ERR.
- evt_ready=0 with 5 STEP_ERR events at counts 0x21, 0x23, 0x25, 0x27, 0x29 -> 4 records held, overflow=1 after the 5th; draining returns 0x21, 0x23, 0x25, 0x27 in order, then evt_valid=0.
- FIFO full while evt_ready=1 and a new event arrive in the same cycle -> head popped, new record appended, overflow stays 0, occupancy stays 4.
- reset pulled low mid-drain for 4 ns -> evt_valid=0 immediately; after release, count_in=0x57 on the first enabled sample -> no event (PRIME), next sample 0x58 -> no event.
- clear=1 with 3 queued records and overflow=1 -> next cycle evt_valid=0, overflow=0; the following sample produces no event (re-prime).
